// File: rtl/alu_muldiv_seq.sv
// Multicycle multiply/divide sequencer that borrows the shared ALU add/sub path.
// MUL/MULHU use shift-add; DIVU/REMU use restoring shift-subtract (one bit per ITER cycle).
// Optional feature macro: MULDIV_SIGNED_EN makes DIV/REM signed by negating operands in
// PRE_A/PRE_B and the result in POST; without it, DIV/REM behave as DIVU/REMU.
module alu_muldiv_seq #(
  parameter int unsigned      WIDTH  = 32,
  parameter logic [WIDTH-1:0] DIV0_Q = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_addsel,
  output logic             alu_arithsel,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_z,
  input  logic             alu_cflag
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [2:0] {StIdle, StPreA, StPreB, StIter, StPost, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [2:0]       op_q, op_d;
  // acc holds hi (multiply) or the partial remainder (divide)
  logic [WIDTH-1:0] acc_q, acc_d;
  // lo holds the multiplier bits (multiply) or the dividend/quotient (divide)
  logic [WIDTH-1:0] lo_q, lo_d;
  // opnd holds the multiplicand or the divisor
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] div_rs;
  logic             op_div, op_rem, op_mulhu;
`ifdef MULDIV_SIGNED_EN
  logic             op_sgn;
  logic             a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic             post_flip;
  logic [WIDTH-1:0] post_val;
`endif

  assign op_div   = op_q[2];
  assign op_rem   = op_q[2] & op_q[0];
  assign op_mulhu = (op_q == 3'b001);
  // Remainder shifted left with the next dividend bit; its old MSB is checked separately
  assign div_rs   = {acc_q[WIDTH-2:0], lo_q[WIDTH-1]};
`ifdef MULDIV_SIGNED_EN
  assign op_sgn    = op_q[2] & op_q[1];
  assign post_flip = op_rem ? a_neg_q : (a_neg_q ^ b_neg_q);
  assign post_val  = op_rem ? acc_q : lo_q;
`endif

  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);
  assign result       = result_q;
  assign alu_arithsel = 1'b0;
  assign alu_sel      = 3'b000;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
`ifdef MULDIV_SIGNED_EN
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
`ifdef MULDIV_SIGNED_EN
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
`endif
    end
  end

  // Next-state, datapath update and ALU drive decoded from the registered state
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    op_d       = op_q;
    acc_d      = acc_q;
    lo_d       = lo_q;
    opnd_d     = opnd_q;
    result_d   = result_q;
    alu_a      = '0;
    alu_b      = '0;
    alu_addsel = 1'b0;
`ifdef MULDIV_SIGNED_EN
    a_neg_d    = a_neg_q;
    b_neg_d    = b_neg_q;
`endif

    case (state_q)
      StIdle: begin
        if (start && !flush) begin
          op_d    = op;
          acc_d   = '0;
          lo_d    = src_a;
          opnd_d  = src_b;
          count_d = '0;
          if (op[2] && (src_b == '0)) begin
            // Divide-by-zero bypasses the iteration entirely
            state_d  = StDone;
            result_d = op[0] ? src_a : DIV0_Q;
          end
`ifdef MULDIV_SIGNED_EN
          else if (op[2] && op[1]) begin
            state_d = StPreA;
          end
`endif
          else begin
            state_d = StIter;
          end
        end
      end

`ifdef MULDIV_SIGNED_EN
      StPreA: begin
        // Magnitude of the dividend: 0 - a
        alu_b      = lo_q;
        alu_addsel = 1'b1;
        a_neg_d    = lo_q[WIDTH-1];
        if (lo_q[WIDTH-1]) lo_d = alu_z;
        state_d    = StPreB;
      end

      StPreB: begin
        alu_b      = opnd_q;
        alu_addsel = 1'b1;
        b_neg_d    = opnd_q[WIDTH-1];
        if (opnd_q[WIDTH-1]) opnd_d = alu_z;
        state_d    = StIter;
      end

      StPost: begin
        alu_b      = post_val;
        alu_addsel = 1'b1;
        result_d   = post_flip ? alu_z : post_val;
        state_d    = StDone;
      end
`endif

      StIter: begin
        if (op_div) begin
          alu_a      = div_rs;
          alu_b      = opnd_q;
          alu_addsel = 1'b1;
          // A set MSB means the shifted remainder exceeds any divisor; the wrapped z is exact
          if (acc_q[WIDTH-1] || !alu_cflag) begin
            acc_d = alu_z;
            lo_d  = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = div_rs;
            lo_d  = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          alu_a = acc_q;
          alu_b = lo_q[0] ? opnd_q : '0;
          acc_d = {alu_cflag, alu_z[WIDTH-1:1]};
          lo_d  = {alu_z[0], lo_q[WIDTH-1:1]};
        end
        count_d = count_q + 1'b1;
        if (count_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
          if (op_div) result_d = op_rem ? acc_d : lo_d;
          else        result_d = op_mulhu ? acc_d : lo_d;
`ifdef MULDIV_SIGNED_EN
          if (op_sgn) begin
            state_d  = StPost;
            result_d = result_q;
          end
`endif
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort: back to idle without a done pulse; result keeps its prior value
    if (flush && (state_q != StIdle)) begin
      state_d  = StIdle;
      count_d  = '0;
      result_d = result_q;
    end
  end

endmodule
